// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and in-order instruction-fetch stage feeding decode.
// Latency: request accepted in cycle t, response in t+L, instruction valid to decode from t+L+1.
// Backpressure: valid/ready on the memory request side; credits (outstanding + buffered)
//   stop issue when the buffer could overflow; decode stalls via instReady.
//
// Ports:
//   i_clk / i_rst_n           clock (rising edge), asynchronous active-low reset
//   i_redirect/i_redirect_pc  load a new fetch PC (low two bits forced to 0) and flush
//   o_fetch_pc                address of the next request, feeds the next-PC generator
//   o_imem_req_*              request to instruction memory (addr == o_fetch_pc)
//   i_imem_resp_*             in-order responses, no backpressure
//   o_inst_* / i_inst_rdy     buffer head (instruction word + its PC) towards decode

// Small synchronous FIFO with synchronous clear, used for both the PC-tag queue and
// the instruction buffer. Push/pop in the same cycle keep the count unchanged.
// The caller guarantees no push when full and no pop when empty.
module pc_fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_dat,
  input  logic          i_pop,
  output logic [W-1:0]  o_head_dat,
  output logic [CW-1:0] o_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (i_push && !i_pop)      r_count <= r_count + CW'(1);
      else if (!i_push && i_pop) r_count <= r_count - CW'(1);
    end
  end

  // Storage needs no reset: nothing reads an entry before it has been written.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_clr) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;
endmodule

module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          BUF_DEPTH       = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_fetch_pc,
  output logic        o_imem_req_vld,
  input  logic        i_imem_req_rdy,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_resp_vld,
  input  logic [31:0] i_imem_resp_dat,
  output logic        o_inst_vld,
  input  logic        i_inst_rdy,
  output logic [31:0] o_inst_dat,
  output logic [31:0] o_inst_pc
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = $clog2(BUF_DEPTH + 1);
  localparam logic [31:0] MAX_OUT_U   = MAX_OUTSTANDING;
  localparam logic [31:0] BUF_DEPTH_U = BUF_DEPTH;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dat;
  } inst_ent_t;

  logic [31:0]   r_fetch_pc;
  logic [OW-1:0] r_outst;     // accepted requests still waiting for a response
  logic [OW-1:0] r_drop;      // of those, how many belong to a flushed stream
  logic          r_run;       // holds request valid low until the first edge after reset

  logic [BW-1:0] w_buf_cnt;
  logic [OW-1:0] w_tag_cnt_unused;
  logic [31:0]   w_tag_pc;
  inst_ent_t     w_head;
  inst_ent_t     w_push_ent;
  logic          w_resp;
  logic          w_keep_resp;
  logic          w_credit;
  logic          w_req_vld;
  logic          w_issue;
  logic          w_pop;
  logic          w_unused_lsb;

  // A response with nothing outstanding is a protocol error and is ignored entirely.
  assign w_resp = i_imem_resp_vld && (r_outst != '0);

  // Stale responses (pending drops, or one arriving during a redirect) never reach
  // the buffer and never pop a tag: the tag queue was cleared on redirect, so it only
  // ever holds tags for requests of the current stream.
  assign w_keep_resp = w_resp && !i_redirect && (r_drop == '0);

  // Counting outstanding requests against buffer space guarantees every response
  // finds a free slot, so the response path needs no backpressure.
  assign w_credit  = (32'(r_outst) < MAX_OUT_U) &&
                     ((32'(r_outst) + 32'(w_buf_cnt)) < BUF_DEPTH_U);
  assign w_req_vld = r_run && !i_redirect && w_credit;
  assign w_issue   = w_req_vld && i_imem_req_rdy;
  assign w_pop     = o_inst_vld && i_inst_rdy;

  assign w_push_ent.pc  = w_tag_pc;
  assign w_push_ent.dat = i_imem_resp_dat;

  pc_fetch_fifo #(
    .W     (32),
    .DEPTH (MAX_OUTSTANDING),
    .CW    (OW)
  ) u_tag_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (i_redirect),
    .i_push     (w_issue),
    .i_push_dat (r_fetch_pc),
    .i_pop      (w_keep_resp),
    .o_head_dat (w_tag_pc),
    .o_count    (w_tag_cnt_unused)
  );

  pc_fetch_fifo #(
    .W     ($bits(inst_ent_t)),
    .DEPTH (BUF_DEPTH),
    .CW    (BW)
  ) u_inst_buf (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (i_redirect),
    .i_push     (w_keep_resp),
    .i_push_dat (w_push_ent),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_count    (w_buf_cnt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run      <= 1'b0;
      r_fetch_pc <= {RESET_PC[31:2], 2'b00};
      r_outst    <= '0;
      r_drop     <= '0;
    end else begin
      r_run <= 1'b1;

      if (i_redirect)   r_fetch_pc <= {i_redirect_pc[31:2], 2'b00};
      else if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;

      // No issue happens during a redirect, so this covers that cycle as well.
      if (w_issue && !w_resp)      r_outst <= r_outst + OW'(1);
      else if (!w_issue && w_resp) r_outst <= r_outst - OW'(1);

      // Everything still outstanding after a redirect is stale. Recomputing from
      // r_outst (instead of adding to r_drop) keeps back-to-back redirects exact.
      if (i_redirect)                   r_drop <= w_resp ? (r_outst - OW'(1)) : r_outst;
      else if (w_resp && r_drop != '0)  r_drop <= r_drop - OW'(1);
    end
  end

  assign w_unused_lsb = ^i_redirect_pc[1:0];

  assign o_fetch_pc      = r_fetch_pc;
  assign o_imem_req_vld  = w_req_vld;
  assign o_imem_req_addr = r_fetch_pc;
  assign o_inst_vld      = (w_buf_cnt != '0);
  // Head fields read as zero while the buffer is empty (including during reset).
  assign o_inst_dat      = o_inst_vld ? w_head.dat : 32'd0;
  assign o_inst_pc       = o_inst_vld ? w_head.pc  : 32'd0;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed bench for pc_fetch_unit with a latency-programmable memory model.
// Latency: memory answers each accepted request a programmable number of cycles later.
// Backpressure: bench drives request ready and decode ready directly per test step.
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_pc;
  logic        req_vld;
  logic        req_rdy;
  logic [31:0] req_addr;
  logic        resp_vld;
  logic [31:0] resp_dat;
  logic        inst_vld;
  logic        inst_rdy;
  logic [31:0] inst_dat;
  logic [31:0] inst_pc;

  logic [31:0] fetch_pc2;
  logic        req2_vld;
  logic [31:0] req2_addr;
  logic        inst2_vld;
  logic [31:0] inst2_dat;
  logic [31:0] inst2_pc;

  pc_fetch_unit #(
    .RESET_PC        (32'h0040_0000),
    .BUF_DEPTH       (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_redirect      (redirect),
    .i_redirect_pc   (redirect_pc),
    .o_fetch_pc      (fetch_pc),
    .o_imem_req_vld  (req_vld),
    .i_imem_req_rdy  (req_rdy),
    .o_imem_req_addr (req_addr),
    .i_imem_resp_vld (resp_vld),
    .i_imem_resp_dat (resp_dat),
    .o_inst_vld      (inst_vld),
    .i_inst_rdy      (inst_rdy),
    .o_inst_dat      (inst_dat),
    .o_inst_pc       (inst_pc)
  );

  // Second instance: wrap-around reset PC, default sizes, memory never answers.
  pc_fetch_unit #(
    .RESET_PC (32'hFFFF_FFFC)
  ) dut2 (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_redirect      (1'b0),
    .i_redirect_pc   (32'd0),
    .o_fetch_pc      (fetch_pc2),
    .o_imem_req_vld  (req2_vld),
    .i_imem_req_rdy  (1'b1),
    .o_imem_req_addr (req2_addr),
    .i_imem_resp_vld (1'b0),
    .i_imem_resp_dat (32'd0),
    .o_inst_vld      (inst2_vld),
    .i_inst_rdy      (1'b0),
    .o_inst_dat      (inst2_dat),
    .o_inst_pc       (inst2_pc)
  );

  int total = 0;
  int bad   = 0;
  int cyc;
  int lat;
  logic force_resp;
  logic [31:0] exp_next;
  logic [31:0] base;

  logic [31:0] iss_q[$];
  logic [31:0] iss2_q[$];
  logic [31:0] del_pc_q[$];
  logic [31:0] del_dat_q[$];
  int          del_cyc_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    iss_q.delete();
    del_pc_q.delete();
    del_dat_q.delete();
    del_cyc_q.delete();
  endtask

  // Called at posedge+1: drive the memory response, sample at posedge+2, advance one cycle.
  task automatic step();
    if (force_resp) begin
      resp_vld   = 1'b1;
      resp_dat   = 32'hDEAD_BEEF;
      force_resp = 1'b0;
    end else if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      resp_vld = 1'b1;
      resp_dat = mem_f(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      resp_vld = 1'b0;
      resp_dat = 32'd0;
    end
    #1;
    if (redirect) chk("redir_no_req", 32'(req_vld), 32'd0);
    if (req_vld && req_rdy) begin
      chk("issue_addr", req_addr, exp_next);
      iss_q.push_back(req_addr);
      pend_addr.push_back(req_addr);
      pend_due.push_back(cyc + lat);
      exp_next = exp_next + 32'd4;
    end
    if (redirect) exp_next = {redirect_pc[31:2], 2'b00};
    if (inst_vld && inst_rdy) begin
      del_pc_q.push_back(inst_pc);
      del_dat_q.push_back(inst_dat);
      del_cyc_q.push_back(cyc);
    end
    if (req2_vld) iss2_q.push_back(req2_addr);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    req_rdy  = 1'b0;
    inst_rdy = 1'b1;
    repeat (10) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    req_rdy     = 1'b1;
    resp_vld    = 1'b0;
    resp_dat    = 32'd0;
    inst_rdy    = 1'b0;
    force_resp  = 1'b0;
    lat         = 1;
    cyc         = 0;
    exp_next    = 32'h0040_0000;

    // Reset state
    #12;
    chk("rst_req_vld",  32'(req_vld),  32'd0);
    chk("rst_inst_vld", 32'(inst_vld), 32'd0);
    chk("rst_inst_dat", inst_dat,      32'd0);
    chk("rst_inst_pc",  inst_pc,       32'd0);
    chk("rst_fetch_pc", fetch_pc,      32'h0040_0000);
    chk("rst2_fetch_pc", fetch_pc2,    32'hFFFF_FFFC);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming, L=1, decode always ready
    inst_rdy = 1'b1;
    repeat (12) step();
    chk("first_req",  iss_q[0], 32'h0040_0000);
    chk("second_req", iss_q[1], 32'h0040_0004);
    for (int k = 0; k < 6; k++) begin
      chk("stream_pc",  del_pc_q[k],  32'h0040_0000 + 32'(4 * k));
      chk("stream_cyc", 32'(del_cyc_q[k]), 32'(k + 2));
    end
    for (int k = 0; k < 3; k++)
      chk("stream_dat", del_dat_q[k], mem_f(32'h0040_0000 + 32'(4 * k)));

    // Request held while not ready: valid stays up, address stable
    drain();
    chk("hold_vld",  32'(req_vld), 32'd1);
    chk("hold_addr", req_addr,     exp_next);
    chk("stream_no_loss", 32'(del_pc_q.size()), 32'd12);

    // Wrap-around of the fetch PC
    chk("wrap_cnt",  32'(iss2_q.size()), 32'd2);
    chk("wrap_req0", iss2_q[0], 32'hFFFF_FFFC);
    chk("wrap_req1", iss2_q[1], 32'h0000_0000);
    chk("wrap_fetch_pc", fetch_pc2, 32'h0000_0004);
    chk("wrap_no_inst", 32'(inst2_vld), 32'd0);

    // Decode stalled: exactly BUF_DEPTH requests, then in-order delivery
    clear_logs();
    base     = exp_next;
    req_rdy  = 1'b1;
    inst_rdy = 1'b0;
    repeat (10) step();
    chk("stall_issued", 32'(iss_q.size()), 32'd4);
    chk("stall_req_vld", 32'(req_vld), 32'd0);
    chk("stall_inst_vld", 32'(inst_vld), 32'd1);
    inst_rdy = 1'b1;
    repeat (10) step();
    for (int k = 0; k < 6; k++)
      chk("stall_pc", del_pc_q[k], base + 32'(4 * k));
    chk("stall_dat3", del_dat_q[3], mem_f(base + 32'd12));
    drain();

    // Single redirect with two requests outstanding (L=3)
    clear_logs();
    lat      = 3;
    inst_rdy = 1'b0;
    req_rdy  = 1'b1;
    repeat (2) step();
    redirect    = 1'b1;
    redirect_pc = 32'h0040_0103;
    step();
    redirect = 1'b0;
    inst_rdy = 1'b1;
    repeat (10) step();
    chk("redir_pc0",  del_pc_q[0],  32'h0040_0100);
    chk("redir_dat0", del_dat_q[0], mem_f(32'h0040_0100));
    chk("redir_pc1",  del_pc_q[1],  32'h0040_0104);
    drain();

    // Back-to-back redirects with a full-ish buffer and one request outstanding (L=2)
    clear_logs();
    lat      = 2;
    inst_rdy = 1'b0;
    req_rdy  = 1'b1;
    repeat (4) step();
    redirect    = 1'b1;
    redirect_pc = 32'h0040_0200;
    step();
    redirect_pc = 32'h0040_0300;
    step();
    redirect = 1'b0;
    inst_rdy = 1'b1;
    repeat (10) step();
    chk("b2b_pc0",  del_pc_q[0],  32'h0040_0300);
    chk("b2b_dat0", del_dat_q[0], mem_f(32'h0040_0300));
    chk("b2b_pc1",  del_pc_q[1],  32'h0040_0304);
    drain();

    // Spurious response with nothing outstanding is ignored
    force_resp = 1'b1;
    step();
    chk("spurious_inst_vld", 32'(inst_vld), 32'd0);
    clear_logs();
    base     = exp_next;
    lat      = 1;
    req_rdy  = 1'b1;
    inst_rdy = 1'b1;
    repeat (6) step();
    chk("spurious_then_any", 32'(del_pc_q.size() != 0), 32'd1);
    chk("spurious_then_pc",  del_pc_q[0],  base);
    chk("spurious_then_dat", del_dat_q[0], mem_f(base));

    // Asynchronous reset mid-stream
    lat = 2;
    repeat (3) step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_req_vld",  32'(req_vld),  32'd0);
    chk("arst_inst_vld", 32'(inst_vld), 32'd0);
    chk("arst_inst_pc",  inst_pc,       32'd0);
    chk("arst_fetch_pc", fetch_pc,      32'h0040_0000);
    pend_addr.delete();
    pend_due.delete();
    resp_vld = 1'b0;
    resp_dat = 32'd0;
    exp_next = 32'h0040_0000;
    clear_logs();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    lat = 1;
    repeat (6) step();
    chk("restart_req0", iss_q[0],    32'h0040_0000);
    chk("restart_pc0",  del_pc_q[0], 32'h0040_0000);
    chk("restart_pc1",  del_pc_q[1], 32'h0040_0004);
    chk("dut2_inst_dat", inst2_dat, 32'd0);
    chk("dut2_inst_pc",  inst2_pc,  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
